// File: rtl/ysyx_23060208_axi_rd_master_if.sv
// AXI4 read-address and read-data channel bundle between the load initiator and the crossbar.
interface ysyx_23060208_axi_rd_master_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   axi_araddr;
    logic                    axi_arvalid;
    logic [3:0]              axi_arid;
    logic [7:0]              axi_arlen;
    logic [2:0]              axi_arsize;
    logic [1:0]              axi_arburst;
    logic                    axi_arready;
    logic                    axi_rvalid;
    logic [2*DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]              axi_rresp;
    logic                    axi_rlast;
    logic [3:0]              axi_rid;
    logic                    axi_rready;

    modport master (
        output axi_araddr, axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        input  axi_arready,
        input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid,
        output axi_rready
    );

    modport slave (
        input  axi_araddr, axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        output axi_arready,
        output axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid,
        input  axi_rready
    );
endinterface

// File: rtl/ysyx_23060208_axi_rd_master.sv
// Single-outstanding AXI4 read initiator: one load request becomes one single-beat AR/R transaction.
// Optional watchdog enabled by defining YSYX_23060208_AXI_RD_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a load request
// AR     | arvalid high, waiting for arready
// R      | rready high, waiting for the read beat
// RESP   | resp_valid high, waiting for the core to take it
module ysyx_23060208_axi_rd_master #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_size,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    input  logic                  resp_ready,
    ysyx_23060208_axi_rd_master_if.master axi
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
    logic [2:0]            arsize_q, arsize_d;
    logic                  rready_q, rready_d;

    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] extracted;
    logic [2:0]            size_clamped;

    // araddr/arsize double as the latched request for data extraction
    always_comb begin
        lane    = araddr_q[2] ? axi.axi_rdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : axi.axi_rdata[DATA_WIDTH-1:0];
        shifted = lane >> {araddr_q[1:0], 3'b000};
        case (arsize_q)
            3'd0:    extracted = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'd1:    extracted = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
        size_clamped = (req_size > 3'd2) ? 3'd2 : req_size;
    end

`ifdef YSYX_23060208_AXI_RD_TIMEOUT_EN
    localparam int CW = 16;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    wire unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arsize_d     = arsize_q;
        rready_d     = rready_q;
`ifdef YSYX_23060208_AXI_RD_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    araddr_d    = req_addr;
                    arsize_d    = size_clamped;
                    req_ready_d = 1'b0;
                    arvalid_d   = 1'b1;
                    state_d     = S_AR;
`ifdef YSYX_23060208_AXI_RD_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            S_AR: begin
                if (arvalid_q && axi.axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (rready_q && axi.axi_rvalid) begin
                    rready_d     = 1'b0;
                    resp_data_d  = extracted;
                    resp_err_d   = (axi.axi_rresp != 2'b00) || (axi.axi_rid != AXI_ID) ||
                                   !axi.axi_rlast;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef YSYX_23060208_AXI_RD_TIMEOUT_EN
        // A beat landing on the expiry cycle wins; otherwise abandon the transaction.
        if (state_q == S_AR || state_q == S_R) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_d == CW'(TIMEOUT) && (state_d == S_AR || state_d == S_R)) begin
                arvalid_d    = 1'b0;
                rready_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_data_d  = '0;
                state_d      = S_RESP;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arsize_q     <= 3'd0;
            rready_q     <= 1'b0;
`ifdef YSYX_23060208_AXI_RD_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arsize_q     <= arsize_d;
            rready_q     <= rready_d;
`ifdef YSYX_23060208_AXI_RD_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_err        = resp_err_q;
    assign axi.axi_araddr  = araddr_q;
    assign axi.axi_arvalid = arvalid_q;
    assign axi.axi_arid    = AXI_ID;
    assign axi.axi_arlen   = 8'd0;
    assign axi.axi_arsize  = arsize_q;
    assign axi.axi_arburst = 2'b01;
    assign axi.axi_rready  = rready_q;

endmodule

// File: tb/tb_ysyx_23060208_axi_rd_master.sv
// Directed bench for the AXI read initiator with an expected-response scoreboard.
module tb_ysyx_23060208_axi_rd_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] sb[$];

    ysyx_23060208_axi_rd_master_if #(.DATA_WIDTH(32)) axi_if ();

    ysyx_23060208_axi_rd_master #(
        .DATA_WIDTH(32),
        .AXI_ID    (4'd0),
        .TIMEOUT   (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .resp_ready(resp_ready),
        .axi       (axi_if)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [2:0] s,
                                          input logic [63:0] d);
        logic [31:0] w;
        w = a[2] ? d[63:32] : d[31:0];
        w = w >> (8 * a[1:0]);
        case (s)
            3'd0:    return {24'd0, w[7:0]};
            3'd1:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic idle_bus();
        axi_if.axi_arready = 1'b0;
        axi_if.axi_rvalid  = 1'b0;
        axi_if.axi_rdata   = 64'h0;
        axi_if.axi_rresp   = 2'b00;
        axi_if.axi_rid     = 4'h0;
        axi_if.axi_rlast   = 1'b1;
    endtask

    task automatic accept(input string tag, input logic [31:0] addr, input logic [2:0] size);
        int w;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        if (req_ready !== 1'b1) chk({tag, ".req_ready_wait"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_size  = size;
        step();
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_size  = 3'd0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] size,
                           input logic [63:0] rdata, input logic [1:0] rresp,
                           input logic [3:0] rid, input logic rlast,
                           input int ar_st, input int r_st, input int rs_st,
                           input logic [31:0] exp_d, input logic exp_e);
        logic [32:0] e;
        logic [2:0]  exp_sz;
        exp_sz = (size > 3'd2) ? 3'd2 : size;
        sb.push_back({exp_e, exp_d});
        accept(tag, addr, size);
        // AR phase: stray rvalid must be ignored here
        for (int i = 0; i <= ar_st; i++) begin
            axi_if.axi_rvalid  = 1'b1;
            axi_if.axi_rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
            axi_if.axi_arready = (i == ar_st);
            if (i == 0 || i == ar_st) begin
                chk({tag, ".arvalid"}, {63'd0, axi_if.axi_arvalid}, 64'd1);
                chk({tag, ".araddr"}, {32'd0, axi_if.axi_araddr}, {32'd0, addr});
                chk({tag, ".rready_in_ar"}, {63'd0, axi_if.axi_rready}, 64'd0);
            end
            if (i == 0) begin
                chk({tag, ".arsize"}, {61'd0, axi_if.axi_arsize}, {61'd0, exp_sz});
                chk({tag, ".arlen_burst_id"},
                    {50'd0, axi_if.axi_arlen, axi_if.axi_arburst, axi_if.axi_arid}, {50'd0, 8'd0, 2'b01, 4'd0});
            end
            step();
        end
        idle_bus();
        for (int i = 0; i <= r_st; i++) begin
            chk({tag, ".r_phase"}, {61'd0, axi_if.axi_rready, axi_if.axi_arvalid, resp_valid}, {61'd0, 3'b100});
            if (i == r_st) begin
                axi_if.axi_rvalid = 1'b1;
                axi_if.axi_rdata  = rdata;
                axi_if.axi_rresp  = rresp;
                axi_if.axi_rid    = rid;
                axi_if.axi_rlast  = rlast;
            end
            step();
        end
        idle_bus();
        chk({tag, ".resp_valid"}, {62'd0, resp_valid, axi_if.axi_rready}, {62'd0, 2'b10});
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".data"}, {32'd0, resp_data}, {32'd0, e[31:0]});
            chk({tag, ".err"}, {63'd0, resp_err}, {63'd0, e[32]});
        end
        for (int i = 0; i < rs_st; i++) begin
            step();
            chk({tag, ".resp_hold"}, {30'd0, resp_valid, resp_err, resp_data, req_ready},
                {30'd0, 1'b1, e[32], e[31:0], 1'b0});
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, ".after_resp"}, {62'd0, resp_valid, req_ready}, {62'd0, 2'b01});
    endtask

    initial begin
        logic [31:0] ra;
        logic [63:0] rd;
        logic [2:0]  rs;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_size   = 3'd0;
        resp_ready = 1'b0;
        idle_bus();
        step();
        step();
        chk("reset_outputs",
            {req_ready, resp_valid, resp_err, axi_if.axi_arvalid, axi_if.axi_rready,
             resp_data, axi_if.axi_arsize},
            {5'b00000, 32'd0, 3'd0});
        chk("reset_araddr", {32'd0, axi_if.axi_araddr}, 64'd0);
        reset = 1'b1;
        chk("req_ready_before_edge", {63'd0, req_ready}, 64'd0);
        step();
        chk("req_ready_first", {63'd0, req_ready}, 64'd1);

        do_read("word", 32'h0200_0000, 3'd2, 64'h0000_0001_1234_5678, 2'b00, 4'h0, 1'b1,
                0, 0, 0, 32'h1234_5678, 1'b0);
        do_read("byte", 32'h0200_0007, 3'd0, 64'hAB00_0000_0000_0000, 2'b00, 4'h0, 1'b1,
                0, 0, 0, 32'h0000_00AB, 1'b0);
        do_read("half", 32'h0200_0002, 3'd1, 64'h0000_0000_BEEF_0000, 2'b00, 4'h0, 1'b1,
                0, 0, 0, 32'h0000_BEEF, 1'b0);
        do_read("stall", 32'h0200_0104, 3'd2, 64'hCAFE_F00D_0000_0000, 2'b00, 4'h0, 1'b1,
                4, 3, 2, 32'hCAFE_F00D, 1'b0);
        do_read("rresp", 32'h0200_0000, 3'd2, 64'h0000_0000_1111_2222, 2'b10, 4'h0, 1'b1,
                0, 1, 0, 32'h1111_2222, 1'b1);
        do_read("rid", 32'h0200_0001, 3'd0, 64'h0000_0000_0000_5500, 2'b00, 4'h3, 1'b1,
                1, 0, 1, 32'h0000_0055, 1'b1);
        do_read("rlast", 32'h0200_0004, 3'd1, 64'h0000_7777_0000_0000, 2'b00, 4'h0, 1'b0,
                0, 0, 0, 32'h0000_7777, 1'b1);
        do_read("clamp", 32'h0000_0005, 3'd7, 64'h1122_3344_5566_7788, 2'b00, 4'h0, 1'b1,
                0, 0, 0, 32'h0011_2233, 1'b0);
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rd = {$urandom, $urandom};
            rs = 3'($urandom_range(0, 7));
            do_read("rand", ra, rs, rd, 2'b00, 4'h0, 1'b1,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                    model(ra, rs, rd), 1'b0);
        end

        // Abort in R: no response may surface afterwards
        sb.push_back({1'b0, 32'h0});
        accept("abort", 32'h0200_0010, 3'd2);
        axi_if.axi_arready = 1'b1;
        step();
        axi_if.axi_arready = 1'b0;
        chk("abort.in_r", {63'd0, axi_if.axi_rready}, 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        void'(sb.pop_front());
        chk("abort.outputs",
            {req_ready, resp_valid, resp_err, axi_if.axi_arvalid, axi_if.axi_rready,
             resp_data, axi_if.axi_arsize},
            {5'b00000, 32'd0, 3'd0});
        chk("abort.araddr", {32'd0, axi_if.axi_araddr}, 64'd0);
        axi_if.axi_rvalid = 1'b1;
        axi_if.axi_rdata  = 64'h1234;
        step();
        chk("abort.idle", {61'd0, req_ready, resp_valid, axi_if.axi_rready}, {61'd0, 3'b100});
        step();
        chk("abort.no_resp", {62'd0, resp_valid, axi_if.axi_rready}, 64'd0);
        idle_bus();
        do_read("post_abort", 32'h0200_0003, 3'd0, 64'h0000_0000_9900_0000, 2'b00, 4'h0, 1'b1,
                0, 0, 0, 32'h0000_0099, 1'b0);

`ifdef YSYX_23060208_AXI_RD_TIMEOUT_EN
        sb.push_back({1'b1, 32'h0});
        accept("tmo", 32'h0200_0020, 3'd2);
        axi_if.axi_arready = 1'b1;
        step();
        axi_if.axi_arready = 1'b0;
        for (int c = 2; c < 16; c++) step();
        chk("tmo.cycle16", {63'd0, resp_valid}, 64'd0);
        step();
        chk("tmo.cycle17", {61'd0, resp_valid, resp_err, axi_if.axi_rready}, {61'd0, 3'b110});
        void'(sb.pop_front());
        chk("tmo.data", {32'd0, resp_data}, 64'd0);
        axi_if.axi_rvalid = 1'b1;
        axi_if.axi_rdata  = 64'h5555_5555_5555_5555;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        step();
        idle_bus();
        chk("tmo.late_beat", {62'd0, resp_valid, req_ready}, {62'd0, 2'b01});
`endif

        chk("sb_drained", {32'd0, sb.size()}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_axi_rd_master.md
# ysyx_23060208_axi_rd_master

Single-outstanding AXI4 read initiator that turns a simple load request from the core (address plus size) into one single-beat AR/R transaction. It extracts the addressed byte, halfword or word from the 64-bit R data and returns it zero-extended with an error flag. It sits between the LSU and the AXI crossbar, on the initiator side of the same read channels that the CLINT and other memory-mapped responders implement.

## Interface
- DATA_WIDTH, 32, width of request address and response data; the R data bus is 2*DATA_WIDTH.
- AXI_ID, 4'd0, value driven on axi_arid and expected on axi_rid.
- TIMEOUT, 255, watchdog limit in cycles; used only when the timeout macro is defined.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
- req_valid  in  1  load request valid.
- req_addr  in  DATA_WIDTH  byte address.
- req_size  in  3  0=byte, 1=half, 2=word; 3..7 treated as 2.
- req_ready  out  1  request accepted when req_valid && req_ready.
- resp_valid  out  1  response valid.
- resp_data  out  DATA_WIDTH  extracted, zero-extended load data.
- resp_err  out  1  response carries an error.
- resp_ready  in  1  core accepts the response.
- axi_araddr  out  DATA_WIDTH  AR address (unaligned address passed through).
- axi_arvalid  out  1  AR valid.
- axi_arid  out  4  constant AXI_ID.
- axi_arlen  out  8  constant 0.
- axi_arsize  out  3  clamped req_size.
- axi_arburst  out  2  constant 2'b01 (INCR).
- axi_arready  in  1  AR ready.
- axi_rvalid  in  1  R valid.
- axi_rdata  in  2*DATA_WIDTH  R data.
- axi_rresp  in  2  R response.
- axi_rlast  in  1  R last.
- axi_rid  in  4  R ID.
- axi_rready  out  1  R ready.

## Operation
- All outputs are registered.
- Reset values:
  - req_ready, resp_valid, resp_err, axi_arvalid, axi_rready = 0.
  - resp_data, axi_araddr, axi_arsize = 0.
  - State = IDLE.
- States: IDLE, AR, R, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch req_addr and the clamped size, drop req_ready, go to AR.
- AR:
  - axi_arvalid=1; araddr and arsize are held stable while arvalid=1.
  - On arvalid && arready, drop arvalid, raise axi_rready, go to R.
- R:
  - axi_rready=1.
  - On rvalid && rready, drop rready, capture data, go to RESP.
  - resp_err = (rresp != 2'b00) || (rid != AXI_ID) || !rlast.
- RESP:
  - resp_valid=1; resp_data and resp_err are held stable.
  - On resp_valid && resp_ready, drop resp_valid, raise req_ready, go to IDLE.
- Data extraction:
  - lane = addr[2] ? rdata[63:32] : rdata[31:0].
  - shifted = lane >> (8*addr[1:0]).
  - Mask shifted to 8, 16 or 32 bits by size, then zero-extend.
  - Misalignment is not checked; the shift result is returned as-is.
- In IDLE and AR, axi_rvalid is ignored and rready stays 0.
- Reset mid-transaction: abort immediately; all outputs return to reset values, and no response is delivered for the aborted request.

## Timing
- Minimum latency from request handshake (cycle 0) to resp_valid is 3 cycles:
  - arvalid in cycle 1.
  - rready in cycle 2 (arready=1 in cycle 1).
  - resp_valid in cycle 3 (rvalid=1 in cycle 2).
- Each wait for arready, rvalid or resp_ready adds one cycle per stall cycle.
- After the response handshake at cycle N, req_ready=1 in cycle N+1; at most one request is outstanding.
- The first req_ready=1 is in the cycle after the first posedge with reset==1.

## Configuration
- YSYX_23060208_AXI_RD_TIMEOUT_EN defined:
  - An 8+ bit cycle counter clears on request accept and counts every cycle in AR or R.
  - When the count reaches TIMEOUT, drop arvalid/rready, go to RESP with resp_err=1 and resp_data=0.
  - A late R beat after a timeout is ignored.
- Not defined: no counter; the block waits indefinitely in AR/R, and TIMEOUT is unused.

## Test plan
- Word read, addr 0x0200_0000, size 2, arready/rvalid tied 1, rdata=0x0000_0001_1234_5678 -> resp_valid 3 cycles after accept; resp_data=0x1234_5678; resp_err=0; arlen=0; arburst=01.
- Byte read, addr 0x0200_0007, size 0, rdata=0xAB00_0000_0000_0000 -> resp_data=0x0000_00AB.
- Halfword read, addr 0x0200_0002, size 1, rdata low word 0xBEEF_0000 -> resp_data=0x0000_BEEF.
- Stalls: arready low 4 cycles, rvalid low 3 cycles, resp_ready low 2 cycles -> araddr and arvalid stable throughout; resp_valid held; req_ready=0 until the cycle after the resp handshake.
- Errors:
  - rresp=2'b10 -> resp_err=1.
  - rid=4'h3 with AXI_ID=0 -> resp_err=1.
  - rlast=0 -> resp_err=1.
- reset=0 asserted while in R -> next cycle all outputs 0, state IDLE.
- With the macro: rvalid never asserted, TIMEOUT=16 -> resp_valid with resp_err=1 and resp_data=0 exactly 16 counted cycles after accept.
